// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module : dmem_responder_pkg
// Brief  : Shared state encodings, default sizes and pointer helper for the
//          data-memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_CORES = 4;
  localparam int CORE_ID_W     = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_READ   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Round-robin successor of a core ID, wrapping at n-1 back to 0.
  function automatic logic [CORE_ID_W-1:0] ptr_inc(input logic [CORE_ID_W-1:0] p,
                                                   input int n);
    if (int'(p) >= n - 1) begin
      return '0;
    end
    return p + CORE_ID_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin picker: first requester at or after the
//          pointer, wrapping to core 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import dmem_responder_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [CORE_ID_W-1:0] i_ptr,
  output logic [NUM_CORES-1:0] o_grant,
  output logic [CORE_ID_W-1:0] o_grant_idx,
  output logic                 o_any
);

  logic [NUM_CORES-1:0] w_hi;
  logic [NUM_CORES-1:0] w_sel;
  logic                 w_found;

  // Requests at or above the pointer win; otherwise fall back to the lowest index.
  always_comb begin
    w_hi = '0;
    for (int b = 0; b < NUM_CORES; b++) begin
      w_hi[b] = i_req[b] && (b >= int'(i_ptr));
    end
    w_sel = (|w_hi) ? w_hi : i_req;
  end

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int b = 0; b < NUM_CORES; b++) begin
      if (!w_found && w_sel[b]) begin
        w_found        = 1'b1;
        o_grant[b]     = 1'b1;
        o_grant_idx    = CORE_ID_W'(b);
      end
    end
  end

  assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module : dmem_responder
// Brief  : Round-robin arbitration of per-core load/store requests onto one
//          single-port synchronous RAM, with one-cycle ack to the winner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_CORES = DEF_NUM_CORES
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [NUM_CORES-1:0]       req,
  input  logic [NUM_CORES-1:0]       we,
  input  logic [NUM_CORES*WIDTH-1:0] addr,
  input  logic [NUM_CORES*WIDTH-1:0] wdata,
  output logic [NUM_CORES-1:0]       ack,
  output logic [WIDTH-1:0]           rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [WIDTH-1:0]           mem_addr,
  output logic [WIDTH-1:0]           mem_wdata,
  input  logic [WIDTH-1:0]           mem_rdata
);

  logic [1:0]           r_state;
  logic [CORE_ID_W-1:0] r_ptr;
  logic [CORE_ID_W-1:0] r_grant_idx;
  logic [NUM_CORES-1:0] r_grant;
  logic                 r_we;
  logic [WIDTH-1:0]     r_addr;
  logic [WIDTH-1:0]     r_wdata;
  logic [WIDTH-1:0]     r_rdata;

  logic [NUM_CORES-1:0] w_grant;
  logic [CORE_ID_W-1:0] w_grant_idx;
  logic                 w_any;
  logic                 w_sel_we;
  logic [WIDTH-1:0]     w_sel_addr;
  logic [WIDTH-1:0]     w_sel_wdata;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_arb (
    .i_req       (req),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // One-hot AND-OR select of the winning core's request fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int b = 0; b < NUM_CORES; b++) begin
      if (w_grant[b]) begin
        w_sel_we    = we[b];
        w_sel_addr  = addr[b*WIDTH +: WIDTH];
        w_sel_wdata = wdata[b*WIDTH +: WIDTH];
      end
    end
  end

  // State advances on the falling edge, in step with the core register file.
  always_ff @(negedge Clk) begin
    if (Rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant_idx <= '0;
      r_grant     <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant     <= w_grant;
            r_grant_idx <= w_grant_idx;
            r_we        <= w_sel_we;
            r_addr      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_state <= r_we ? ST_DONE : ST_READ;
        end
        ST_READ: begin
          r_rdata <= mem_rdata;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_ptr   <= ptr_inc(r_grant_idx, NUM_CORES);
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (r_state == ST_ACCESS);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign ack   = (r_state == ST_DONE) ? r_grant : '0;
  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module : tb_dmem_responder
// Brief  : Directed scoreboard bench for dmem_responder with a behavioural RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   we;
  logic [N*W-1:0] addr;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   ack;
  logic [W-1:0]   rdata;
  logic           mem_en;
  logic           mem_we;
  logic [W-1:0]   mem_addr;
  logic [W-1:0]   mem_wdata;
  logic [W-1:0]   mem_rdata;

  logic           tb_req   [N];
  logic           tb_we    [N];
  logic [W-1:0]   tb_addr  [N];
  logic [W-1:0]   tb_wdata [N];

  logic [W-1:0]   ram   [256];
  logic           ram_v [256];
  logic           ram_clr;

  typedef struct {
    logic [1:0] core;
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;

  dmem_responder #(
    .WIDTH     (W),
    .NUM_CORES (N)
  ) dut (
    .Clk       (clk),
    .Rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) ncyc <= ncyc + 1;

  always_comb begin
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      req[i]          = tb_req[i];
      we[i]           = tb_we[i];
      addr[i*W +: W]  = tb_addr[i];
      wdata[i*W +: W] = tb_wdata[i];
    end
  end

  // Unwritten locations read back as addr ^ 8'h5A.
  always @(negedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram_v[i] <= 1'b0;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]   <= mem_wdata;
        ram_v[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_v[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'h5A);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      if (ack !== '0) begin
        chk("ack_onehot", $countones(ack), 1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack=%b required no ack", ack);
        end else begin
          e = sb.pop_front();
          chk("ack_core", {28'd0, ack}, {28'd0, 4'b0001 << e.core});
          if (e.rd) chk("rdata", {24'd0, rdata}, {24'd0, e.data});
          if (e.cyc >= 0) chk("ack_cycle", ncyc, e.cyc);
        end
      end
    end
  endtask

  task automatic core_run(input logic [1:0] c, input bit w, input logic [7:0] a,
                          input logic [7:0] d, input bit push, input logic [7:0] expd);
    int n;
    tb_we[c]    = w;
    tb_addr[c]  = a;
    tb_wdata[c] = d;
    tb_req[c]   = 1'b1;
    if (push) sb.push_back('{c, !w, expd, ncyc + (w ? 2 : 3)});
    n = 0;
    while (n < 80) begin
      @(posedge clk);
      if ((ack & (4'b0001 << c)) != 0) break;
      n++;
    end
    if (n == 80) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: core %0d got no ack required ack within 80 cycles", c);
    end
    tb_req[c] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    ram_clr = 1'b1;
    for (int i = 0; i < N; i++) begin
      tb_req[i]   = 1'b0;
      tb_we[i]    = 1'b0;
      tb_addr[i]  = '0;
      tb_wdata[i] = '0;
    end
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    #2;
    ram_clr = 1'b0;
    do_reset();

    // Single write then read-back by core 0, with ACCESS-cycle RAM signals.
    @(negedge clk); #2;
    fork
      core_run(2'd0, 1'b1, 8'h10, 8'hA5, 1'b1, 8'h00);
      begin
        @(posedge clk);
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
        @(posedge clk);
        chk("acc_mem_en", {31'd0, mem_en}, 32'd1);
        chk("acc_mem_we", {31'd0, mem_we}, 32'd1);
        chk("acc_mem_addr", {24'd0, mem_addr}, 32'h10);
        chk("acc_mem_wdata", {24'd0, mem_wdata}, 32'hA5);
      end
    join
    chk("rdata_after_write", {24'd0, rdata}, 32'd0);
    @(negedge clk); #2;
    core_run(2'd0, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5);

    // All four cores read at once from a fresh pointer.
    do_reset();
    @(negedge clk); #2;
    sb.push_back('{2'd0, 1'b1, 8'h7A, -1});
    sb.push_back('{2'd1, 1'b1, 8'h7B, -1});
    sb.push_back('{2'd2, 1'b1, 8'h78, -1});
    sb.push_back('{2'd3, 1'b1, 8'h79, -1});
    fork
      core_run(2'd0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00);
      core_run(2'd1, 1'b0, 8'h21, 8'h00, 1'b0, 8'h00);
      core_run(2'd2, 1'b0, 8'h22, 8'h00, 1'b0, 8'h00);
      core_run(2'd3, 1'b0, 8'h23, 8'h00, 1'b0, 8'h00);
    join

    // Cores 1 and 3 compete continuously: grants must alternate.
    @(negedge clk); #2;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{2'd1, 1'b1, 8'h1A, -1});
      sb.push_back('{2'd3, 1'b1, 8'h19, -1});
    end
    fork
      begin
        for (int r = 0; r < 3; r++) begin
          core_run(2'd1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h00);
          @(negedge clk); @(negedge clk); #2;
        end
      end
      begin
        for (int s = 0; s < 3; s++) begin
          core_run(2'd3, 1'b0, 8'h43, 8'h00, 1'b0, 8'h00);
          @(negedge clk); @(negedge clk); #2;
        end
      end
    join

    // Core 2 changes its address after grant; the latched 0x30 must be used.
    @(negedge clk); #2;
    fork
      core_run(2'd2, 1'b1, 8'h30, 8'h77, 1'b1, 8'h00);
      begin
        @(posedge clk);
        @(posedge clk);
        chk("hold_mem_addr", {24'd0, mem_addr}, 32'h30);
        tb_addr[2]  = 8'h31;
        tb_wdata[2] = 8'h99;
      end
    join
    @(negedge clk); #2;
    core_run(2'd2, 1'b0, 8'h30, 8'h00, 1'b1, 8'h77);
    @(negedge clk); #2;
    core_run(2'd2, 1'b0, 8'h31, 8'h00, 1'b1, 8'h6B);

    // Reset during core 1's READ: no ack, rdata cleared, pointer back to 0.
    @(negedge clk); #2;
    tb_we[1]   = 1'b0;
    tb_addr[1] = 8'h50;
    tb_req[1]  = 1'b1;
    @(negedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk);
    chk("read_state_ack", {28'd0, ack}, 32'd0);
    @(negedge clk); #2;
    rst       = 1'b0;
    tb_req[1] = 1'b0;
    @(posedge clk);
    chk("abort_rdata", {24'd0, rdata}, 32'd0);
    chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
    repeat (4) @(posedge clk);
    chk("abort_no_ack", {28'd0, ack}, 32'd0);
    @(negedge clk); #2;
    sb.push_back('{2'd0, 1'b1, 8'h5A, -1});
    sb.push_back('{2'd3, 1'b1, 8'hA5, -1});
    fork
      core_run(2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
      core_run(2'd3, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00);
    join

    // Last grant was core 3: core 0 alone wins, then core 1 beats core 0.
    @(negedge clk); #2;
    core_run(2'd0, 1'b1, 8'h80, 8'h3C, 1'b1, 8'h00);
    @(negedge clk); #2;
    sb.push_back('{2'd1, 1'b1, 8'hDB, -1});
    sb.push_back('{2'd0, 1'b1, 8'h3C, -1});
    fork
      core_run(2'd0, 1'b0, 8'h80, 8'h00, 1'b0, 8'h00);
      core_run(2'd1, 1'b0, 8'h81, 8'h00, 1'b0, 8'h00);
    join

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
